// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring step per cycle,
// sign fix-up through the same 2-bit-slice adder, valid/ready on both sides.

module adder_mod #(
  parameter int W = 34
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  localparam int NS = W / 2;
  logic [NS-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NS; gi++) begin : g_slice
    if (gi == NS - 1) begin : g_last
      assign sum_o[2*gi+1:2*gi] = a_i[2*gi+1:2*gi] + b_i[2*gi+1:2*gi] + {1'b0, carry[gi]};
    end else begin : g_mid
      logic [2:0] slice;
      assign slice = {1'b0, a_i[2*gi+1:2*gi]} + {1'b0, b_i[2*gi+1:2*gi]} + {2'b00, carry[gi]};
      assign sum_o[2*gi+1:2*gi] = slice[1:0];
      assign carry[gi+1]        = slice[2];
    end
  end
endmodule

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);
  localparam int AW = WIDTH + 2;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic             op_rem_q;
  logic             signed_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [AW-1:0]    neg_div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;

  logic             is_signed_d;
  logic             dvd_neg_d;
  logic             dvs_neg_d;
  logic [WIDTH-1:0] abs_dvd_d;
  logic [WIDTH-1:0] abs_dvs_d;
  logic [AW-1:0]    neg_div_d;
  logic             div_zero_d;
  logic             overflow_d;

  logic [AW-1:0]    add_a;
  logic [AW-1:0]    add_b;
  logic [AW-1:0]    add_sum;
  logic [WIDTH-1:0] fix_x;
  logic             fix_neg;
  logic             unused_sum_bit;

  assign is_signed_d = ~i_op[0];
  assign dvd_neg_d   = is_signed_d & i_dividend[WIDTH-1];
  assign dvs_neg_d   = is_signed_d & i_divisor[WIDTH-1];
  assign abs_dvd_d   = dvd_neg_d ? (~i_dividend + 1'b1) : i_dividend;
  assign abs_dvs_d   = dvs_neg_d ? (~i_divisor + 1'b1) : i_divisor;
  assign neg_div_d   = ~{2'b00, abs_dvs_d} + 1'b1;
  assign div_zero_d  = (i_divisor == '0);
  assign overflow_d  = is_signed_d && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (i_divisor == '1);

  // Only the selected result ever needs negating, so one adder pass suffices.
  assign fix_x   = op_rem_q ? r_q : q_q;
  assign fix_neg = signed_q & (op_rem_q ? dvd_neg_q : (dvd_neg_q ^ dvs_neg_q));

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      CALC: begin
        add_a = {1'b0, r_q, q_q[WIDTH-1]};
        add_b = neg_div_q;
      end
      FIX: begin
        add_a = {2'b00, ~fix_x};
        add_b = AW'(1);
      end
      default: ;
    endcase
  end

  adder_mod #(.W(AW)) u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  assign unused_sum_bit = add_sum[WIDTH];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      op_rem_q  <= 1'b0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      r_q       <= '0;
      q_q       <= '0;
      neg_div_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_rem_q  <= i_op[1];
            signed_q  <= is_signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            neg_div_q <= neg_div_d;
            if (div_zero_d) begin
              result_q <= i_op[1] ? i_dividend : '1;
              state_q  <= DONE;
            end else if (overflow_d) begin
              result_q <= i_op[1] ? '0 : i_dividend;
              state_q  <= DONE;
            end else begin
              r_q     <= '0;
              q_q     <= abs_dvd_d;
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // Sign bit of S - divisor clear means the divisor fits: keep the difference.
          if (!add_sum[AW-1]) begin
            r_q <= add_sum[WIDTH-1:0];
          end else begin
            r_q <= {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          end
          q_q <= {q_q[WIDTH-2:0], ~add_sum[AW-1]};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          result_q <= fix_neg ? add_sum[WIDTH-1:0] : fix_x;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          // Special cases arrive here with valid still low; raise it one edge later.
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special cases,
// backpressure, flush and asynchronous reset in the middle of an operation.

module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_valid    (valid_in),
    .o_ready    (ready_out),
    .i_op       (op),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .i_flush    (flush),
    .o_valid    (valid_out),
    .i_ready    (ready_in),
    .o_result   (result),
    .o_busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Present a request before the edge, then scramble the inputs after accept.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_in = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    op       = ~o;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h1234_5678;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    chk({tag, ".ready_before"}, {31'd0, ready_out}, 32'd1);
    issue(o, a, b);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'd0, valid_out}, 32'd1);
      chk({tag, ".hold_result"}, result, exp);
      chk({tag, ".hold_ready"}, {31'd0, ready_out}, 32'd0);
    end
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    chk({tag, ".valid_after"}, {31'd0, valid_out}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, ready_out}, 32'd1);
    $display("op %s: %08h / %08h -> %08h in %0d cycles", tag, a, b, result, lat);
  endtask

  initial begin
    bit seen_valid;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;
    ready_in = 1'b0;
    #12;
    chk("reset.valid", {31'd0, valid_out}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.ready", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7",   OP_DIVU, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op("remu_100_7",   OP_REMU, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_7_m2",     OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33, 0);
    run_op("div_min_2",    OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 33, 0);
    run_op("divu_5_0",     OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_m5_0",     OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  0);
    run_op("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("divu_bp",      OP_DIVU, 32'd1000,      32'd3,         32'd333,       33, 10);

    // Flush at iteration 10: unit returns to IDLE and never raises o_valid.
    issue(OP_DIVU, 32'd500, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.ready", {31'd0, ready_out}, 32'd1);
    chk("flush.valid", {31'd0, valid_out}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) seen_valid = 1'b1;
    end
    chk("flush.no_pulse", {31'd0, seen_valid}, 32'd0);
    $display("op flush: operation dropped at iteration 10");

    // Reset at iteration 20 clears outputs immediately, including the old result.
    issue(OP_DIVU, 32'd800, 32'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.valid", {31'd0, valid_out}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.ready", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("op reset: operation discarded at iteration 20");

    run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider for DIV, DIVU, REM and REMU.
- Sits in the execute stage next to the ALU. It feeds operands to an internal adder_mod instance each cycle and consumes its sum to build the quotient and remainder.
- Uses a valid/ready handshake with the issue logic (upstream) and the writeback mux (downstream).
- One operation is in flight at a time; there is no back-to-back pipelining.

Parameters:
- WIDTH, 32, operand/result width. Must be even, because adder_mod works on 2-bit slices.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operation request.
- o_ready  output  1  high only in IDLE; an operation is accepted on a rising edge where i_valid & o_ready.
- i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_dividend  input  WIDTH  rs1 value.
- i_divisor  input  WIDTH  rs2 value.
- i_flush  input  1  synchronous abort from the branch/trap unit.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  quotient or remainder, selected by the latched op.
- o_busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, o_valid = 0, o_result = 0, o_busy = 0, o_ready = 1.
  - All internal registers are cleared.
  - Reset asserted mid-operation discards the operation; no result is ever produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, on accept at edge T:
  - Latch op, signed flag (op[0] == 0), and the dividend/divisor signs (signed ops only).
  - Latch abs(dividend) and abs(divisor). Unsigned ops take the operands as-is.
  - Latch neg_div = two's complement of the zero-extended abs(divisor) at WIDTH+2 bits.
- Divisor == 0 at accept:
  - Go directly to DONE.
  - Quotient = all-ones (0xFFFFFFFF).
  - Remainder = dividend, unmodified.
- Signed op with dividend == 0x80000000 and divisor == 0xFFFFFFFF:
  - Go directly to DONE.
  - Quotient = 0x80000000, remainder = 0.
- Otherwise go to CALC with iteration counter = WIDTH-1, partial remainder R = 0, Q = abs(dividend).
- CALC, one restoring step per edge (WIDTH edges, T+1 .. T+WIDTH):
  - S = {R, Q[MSB]} at WIDTH+2 bits, zero-extended.
  - The internal adder_mod (WIDTH+2 bits) computes D = S + neg_div.
  - If D[MSB] == 0: R = D[WIDTH-1:0] and shift 1 into Q. Else: R = S[WIDTH-1:0] and shift 0 into Q.
  - The counter decrements each step; at counter == 0 the next state is FIX.
- FIX, one edge at T+WIDTH+1:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - Negation = ~x + 1 through the same adder_mod instance; operand muxing happens in this state.
  - Select quotient (op[1] == 0) or remainder into o_result; go to DONE.
- Latency:
  - Normal path: o_valid is high after edge T+WIDTH+1, i.e. WIDTH+1 cycles after accept (33 for WIDTH = 32).
  - Special cases: o_valid is high after edge T+1.
- DONE:
  - o_valid = 1; o_result is held stable until the handshake.
  - On an edge with i_ready = 1: go to IDLE and o_valid = 0. o_result keeps its value; its value in IDLE is don't-care for consumers.
  - The next request can be accepted no earlier than the following edge.
- i_flush:
  - From any state, the next edge forces IDLE and o_valid = 0; the pending result is dropped.
  - i_flush has priority over accept and over the i_ready handshake.
  - When i_flush is high in IDLE, i_valid is ignored on that edge.
- Inputs are don't-care outside accept edges; the unit uses only latched copies.

Test Plan:
- DIVU 100 / 7 -> o_valid exactly 33 cycles after the accept edge, o_result = 14. REMU of the same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM of the same operands -> 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE (-2) -> 0xFFFFFFFD.
- DIVU 5 / 0 -> 0xFFFFFFFF one cycle after accept. REM 0xFFFFFFFB / 0 -> 0xFFFFFFFB.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0, one-cycle path.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE -> o_valid and o_result stable throughout, o_ready = 0. Raise i_ready -> IDLE next edge, o_ready = 1.
- Mid-CALC events:
  - i_flush at iteration 10 -> IDLE next edge, no o_valid pulse.
  - i_reset_n low at iteration 20 -> immediate IDLE with outputs zero.
  - A following DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF in 33 cycles.
